// File: rtl/shift_pkg.sv
// Shared definitions for the shift/serdes engine: FSM state encoding and
// bit-order constants used when latching msb_first.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic MSB_FIRST = 1'b1;
   localparam logic LSB_FIRST = 1'b0;

endpackage

// File: rtl/shift_serdes_engine_if.sv
// Bus bundle for the shift/serdes engine.
//   load_*    : parallel word in (valid/ready), msb_first sampled on accept
//   shift_en  : pacing strobe, serial_in / serial_out : bit-serial link
//   busy      : transfer in progress
//   cap_*     : received word out (valid/ready)
// master = the side driving words and consuming captures, slave = engine.
interface shift_serdes_engine_if #(parameter int WIDTH = 8);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             msb_first;
   logic             shift_en;
   logic             serial_in;
   logic             serial_out;
   logic             busy;
   logic             cap_valid;
   logic             cap_ready;
   logic [WIDTH-1:0] cap_data;

   modport master (
      output load_valid, load_data, msb_first, shift_en, serial_in, cap_ready,
      input  load_ready, serial_out, busy, cap_valid, cap_data
   );

   modport slave (
      input  load_valid, load_data, msb_first, shift_en, serial_in, cap_ready,
      output load_ready, serial_out, busy, cap_valid, cap_data
   );

endinterface

// File: rtl/shift_bit_counter.sv
// Loadable down-counter tracking the shifts remaining in a word.
//   clk, reset : clock, async active-low reset (count cleared to 0)
//   load       : load load_val (takes priority over dec)
//   dec        : decrement by one
//   zero_next  : the decrement happening this cycle brings the count to 0
module shift_bit_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_next
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   assign zero_next = dec && (cnt_q == CNT_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/shift_serdes_engine.sv
// Full-duplex shift engine: accepts a parallel word, shifts it out serially
// (MSB- or LSB-first, paced by shift_en) while capturing serial_in into the
// vacated positions, then presents the captured word on a valid/ready port.
//   clk   : rising-edge clock
//   reset : async active-low reset
//   bus   : shift_serdes_engine_if.slave (load, serial, capture signals)
//
// state | meaning
// IDLE  | load_ready=1, waiting for a word
// SHIFT | busy, serial_out driven, one bit per shift_en cycle
// DONE  | busy, cap_valid=1 with the captured word held until cap_ready
module shift_serdes_engine
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   shift_serdes_engine_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             order_q, order_d;
   logic             cnt_load;
   logic             cnt_dec;
   logic             last_shift;

   logic             load_ready;
   logic             busy;
   logic             cap_valid;
   logic [WIDTH-1:0] cap_data;
   logic             serial_out;

   shift_bit_counter #(.CNT_W(CNT_W)) u_bit_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (cnt_load),
      .load_val  (CNT_W'(WIDTH)),
      .dec       (cnt_dec),
      .zero_next (last_shift)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      order_d    = order_q;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      load_ready = 1'b0;
      busy       = 1'b0;
      cap_valid  = 1'b0;
      cap_data   = '0;
      serial_out = 1'b0;
      case (state_q)
         IDLE: begin
            load_ready = 1'b1;
            if (bus.load_valid) begin
               shreg_d  = bus.load_data;
               order_d  = bus.msb_first;
               cnt_load = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            // Register-only mux so the link sees a glitch-free bit.
            serial_out = (order_q == MSB_FIRST) ? shreg_q[WIDTH-1] : shreg_q[0];
            if (bus.shift_en) begin
               cnt_dec = 1'b1;
               if (order_q == MSB_FIRST) begin
                  shreg_d = {shreg_q[WIDTH-2:0], bus.serial_in};
               end else begin
                  shreg_d = {bus.serial_in, shreg_q[WIDTH-1:1]};
               end
               if (last_shift) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            busy      = 1'b1;
            cap_valid = 1'b1;
            cap_data  = shreg_q;
            if (bus.cap_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         order_q <= LSB_FIRST;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         order_q <= order_d;
      end
   end

   assign bus.load_ready = load_ready;
   assign bus.busy       = busy;
   assign bus.cap_valid  = cap_valid;
   assign bus.cap_data   = cap_data;
   assign bus.serial_out = serial_out;

endmodule

// File: tb/tb_shift_serdes_engine.sv
module tb_shift_serdes_engine;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   shift_serdes_engine_if #(.WIDTH(8))  bus8 ();
   shift_serdes_engine_if #(.WIDTH(2))  bus2 ();
   shift_serdes_engine_if #(.WIDTH(16)) bus16 ();

   logic loop8;
   logic si8;
   assign bus8.serial_in  = loop8 ? bus8.serial_out : si8;
   assign bus2.serial_in  = bus2.serial_out;
   assign bus16.serial_in = bus16.serial_out;

   shift_serdes_engine #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
   shift_serdes_engine #(.WIDTH(2))  u_dut2  (.clk(clk), .reset(reset), .bus(bus2.slave));
   shift_serdes_engine #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

   logic [7:0]  sb8[$];
   logic [1:0]  sb2[$];
   logic [15:0] sb16[$];

   // Offer a word on the 8-bit engine; called and returns at a negedge.
   // msb_first is flipped after acceptance to show only the latched value matters.
   task automatic load8(input logic [7:0] d, input logic msb);
      int n = 0;
      while (bus8.load_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus8.load_ready !== 1'b1) begin
         errors++;
         $display("FAIL load8_ready: got %b expected 1", bus8.load_ready);
      end
      bus8.load_valid = 1'b1;
      bus8.load_data  = d;
      bus8.msb_first  = msb;
      @(negedge clk);
      bus8.load_valid = 1'b0;
      bus8.msb_first  = ~msb;
   endtask

   // Wait for cap_valid, compare against the scoreboard, then consume.
   task automatic receive8(input int budget);
      int n = 0;
      logic [7:0] exp;
      while (bus8.cap_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus8.cap_valid !== 1'b1) begin
         errors++;
         $display("FAIL recv8_timeout: cap_valid got %b expected 1", bus8.cap_valid);
      end else if (sb8.size() == 0) begin
         errors++;
         $display("FAIL recv8_unexpected: got %h expected no word", bus8.cap_data);
      end else begin
         exp = sb8.pop_front();
         if (bus8.cap_data !== exp) begin
            errors++;
            $display("FAIL recv8_data: got %h expected %h", bus8.cap_data, exp);
         end
      end
      bus8.cap_ready = 1'b1;
      @(negedge clk);
      bus8.cap_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus8.load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready: got %b expected 1", bus8.load_ready); end
      checks++;
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus8.busy); end
      checks++;
      if (bus8.cap_valid !== 1'b0) begin errors++; $display("FAIL rst_cap_valid: got %b expected 0", bus8.cap_valid); end
      checks++;
      if (bus8.serial_out !== 1'b0) begin errors++; $display("FAIL rst_serial_out: got %b expected 0", bus8.serial_out); end
      checks++;
      if (bus8.cap_data !== 8'h00) begin errors++; $display("FAIL rst_cap_data: got %h expected 00", bus8.cap_data); end
   endtask

   task automatic test_reset_mid_shift();
      bit seen = 0;
      loop8 = 1'b0;
      si8 = 1'b0;
      bus8.shift_en = 1'b1;
      load8(8'hFF, 1'b1);
      @(negedge clk);
      checks++;
      if (bus8.serial_out !== 1'b1 || bus8.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: serial_out/busy got %b%b expected 11", bus8.serial_out, bus8.busy);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus8.load_ready !== 1'b1 || bus8.busy !== 1'b0 || bus8.serial_out !== 1'b0 || bus8.cap_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_async: ready/busy/sout/cvalid got %b%b%b%b expected 1000",
                  bus8.load_ready, bus8.busy, bus8.serial_out, bus8.cap_valid);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus8.cap_valid === 1'b1) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL mid_no_cap: cap_valid got 1 expected 0"); end
   endtask

   task automatic test_msb_loopback();
      logic [7:0] seq = 8'b1010_0101;
      loop8 = 1'b1;
      bus8.shift_en = 1'b1;
      sb8.push_back(8'hA5);
      load8(8'hA5, 1'b1);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bus8.serial_out !== seq[7-k]) begin
            errors++;
            $display("FAIL msb_bit%0d: got %b expected %b", k, bus8.serial_out, seq[7-k]);
         end
         checks++;
         if (bus8.cap_valid !== 1'b0) begin errors++; $display("FAIL msb_early_cap%0d: got 1 expected 0", k); end
         @(negedge clk);
      end
      checks++;
      if (bus8.cap_valid !== 1'b1) begin errors++; $display("FAIL msb_latency: cap_valid got %b expected 1", bus8.cap_valid); end
      receive8(4);
   endtask

   task automatic test_lsb_capture();
      logic [7:0] sin_seq = 8'b0101_0011;
      loop8 = 1'b0;
      bus8.shift_en = 1'b1;
      sb8.push_back(8'h53);
      load8(8'h00, 1'b0);
      for (int k = 0; k < 8; k++) begin
         si8 = sin_seq[k];
         checks++;
         if (bus8.serial_out !== 1'b0) begin errors++; $display("FAIL lsb_sout%0d: got 1 expected 0", k); end
         @(negedge clk);
      end
      receive8(4);
   endtask

   task automatic test_stall();
      logic [3:0] pat = 4'b1001;
      logic [7:0] word = 8'hF0;
      int en_cnt = 0;
      loop8 = 1'b0;
      si8 = 1'b0;
      sb8.push_back(8'h00);
      load8(word, 1'b1);
      for (int c = 0; c < 64; c++) begin
         if (bus8.cap_valid === 1'b1) break;
         if (en_cnt < 8) begin
            checks++;
            if (bus8.serial_out !== word[7-en_cnt]) begin
               errors++;
               $display("FAIL stall_sout c%0d: got %b expected %b", c, bus8.serial_out, word[7-en_cnt]);
            end
         end
         bus8.shift_en = pat[c%4];
         @(posedge clk);
         if (bus8.shift_en) en_cnt++;
         @(negedge clk);
      end
      checks++;
      if (en_cnt != 8) begin errors++; $display("FAIL stall_count: got %0d enabled cycles expected 8", en_cnt); end
      bus8.shift_en = 1'b1;
      receive8(4);
   endtask

   task automatic test_back_to_back();
      int n = 0;
      logic [7:0] exp = 8'h00;
      loop8 = 1'b1;
      bus8.shift_en = 1'b1;
      sb8.push_back(8'h3C);
      load8(8'h3C, 1'b1);
      while (bus8.cap_valid !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus8.cap_valid !== 1'b1) begin errors++; $display("FAIL b2b_timeout: cap_valid got 0 expected 1"); end
      if (sb8.size() != 0) exp = sb8.pop_front();
      bus8.cap_ready  = 1'b0;
      bus8.load_valid = 1'b1;
      bus8.load_data  = 8'h81;
      bus8.msb_first  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus8.cap_valid !== 1'b1 || bus8.cap_data !== exp || bus8.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold%0d: cvalid/data/ready got %b/%h/%b expected 1/%h/0",
                     k, bus8.cap_valid, bus8.cap_data, bus8.load_ready, exp);
         end
         @(negedge clk);
      end
      bus8.cap_ready = 1'b1;
      @(negedge clk);
      bus8.cap_ready = 1'b0;
      checks++;
      if (bus8.cap_valid !== 1'b0 || bus8.load_ready !== 1'b1 || bus8.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: cvalid/ready/busy got %b%b%b expected 010",
                  bus8.cap_valid, bus8.load_ready, bus8.busy);
      end
      sb8.push_back(8'h81);
      @(negedge clk);
      bus8.load_valid = 1'b0;
      checks++;
      if (bus8.busy !== 1'b1 || bus8.load_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: busy/ready got %b%b expected 10", bus8.busy, bus8.load_ready);
      end
      receive8(12);
   endtask

   task automatic test_sweep_w2();
      logic [1:0] d;
      logic [1:0] exp;
      for (int i = 0; i < 8; i++) begin
         int n = 0;
         d = 2'($urandom);
         while (bus2.load_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
         bus2.load_valid = 1'b1;
         bus2.load_data  = d;
         bus2.msb_first  = i[0];
         sb2.push_back(d);
         @(negedge clk);
         bus2.load_valid = 1'b0;
         n = 0;
         while (bus2.cap_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
         checks++;
         if (bus2.cap_valid !== 1'b1 || sb2.size() == 0) begin
            errors++;
            $display("FAIL w2_timeout%0d: cap_valid got %b expected 1", i, bus2.cap_valid);
         end else begin
            exp = sb2.pop_front();
            if (bus2.cap_data !== exp) begin
               errors++;
               $display("FAIL w2_data%0d: got %h expected %h", i, bus2.cap_data, exp);
            end
         end
         bus2.cap_ready = 1'b1;
         @(negedge clk);
         bus2.cap_ready = 1'b0;
      end
   endtask

   task automatic test_sweep_w16();
      logic [15:0] d;
      logic [15:0] exp;
      for (int i = 0; i < 8; i++) begin
         int n = 0;
         d = 16'($urandom);
         while (bus16.load_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
         bus16.load_valid = 1'b1;
         bus16.load_data  = d;
         bus16.msb_first  = i[0];
         sb16.push_back(d);
         @(negedge clk);
         bus16.load_valid = 1'b0;
         n = 0;
         while (bus16.cap_valid !== 1'b1 && n < 24) begin @(negedge clk); n++; end
         checks++;
         if (bus16.cap_valid !== 1'b1 || sb16.size() == 0) begin
            errors++;
            $display("FAIL w16_timeout%0d: cap_valid got %b expected 1", i, bus16.cap_valid);
         end else begin
            exp = sb16.pop_front();
            if (bus16.cap_data !== exp) begin
               errors++;
               $display("FAIL w16_data%0d: got %h expected %h", i, bus16.cap_data, exp);
            end
         end
         bus16.cap_ready = 1'b1;
         @(negedge clk);
         bus16.cap_ready = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      loop8 = 1'b0;
      si8   = 1'b0;
      bus8.load_valid  = 1'b0; bus8.load_data  = '0; bus8.msb_first  = 1'b1;
      bus8.shift_en    = 1'b0; bus8.cap_ready  = 1'b0;
      bus2.load_valid  = 1'b0; bus2.load_data  = '0; bus2.msb_first  = 1'b1;
      bus2.shift_en    = 1'b1; bus2.cap_ready  = 1'b0;
      bus16.load_valid = 1'b0; bus16.load_data = '0; bus16.msb_first = 1'b1;
      bus16.shift_en   = 1'b1; bus16.cap_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_msb_loopback();
      test_lsb_capture();
      test_stall();
      test_back_to_back();
      test_reset_mid_shift();
      test_sweep_w2();
      test_sweep_w16();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
